mips_multicycle_ctrl: RTL and testbench

- Moore-style control FSM that sequences the multi-cycle MIPS datapath, one instruction phase per clock.
- Drives every datapath mux select (register-destination 5-bit mux, ALU-operand 32-bit muxes, write-back mux, PC-source mux) plus register, memory and IR write enables.
- Sits beside the datapath top level; consumes only the IR opcode field and a memory-ready handshake.
- Supports R-type, lw, sw, beq, j and addi; any other opcode halts the sequencer.

---
 rtl/mips_ctrl_pkg.sv | 57 +++++
 rtl/mips_ctrl_decode.sv | 71 +++++++
 rtl/mips_multicycle_ctrl.sv | 118 +++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: state codes, opcodes,
// mux select values and the bundled control word.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_RD    = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WR    = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EXEC = 4'd10,
        S_ADDI_WB   = 4'd11,
        S_HALT      = 4'd15
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    localparam logic [1:0] ALU_ADD   = 2'd0;
    localparam logic [1:0] ALU_SUB   = 2'd1;
    localparam logic [1:0] ALU_FUNCT = 2'd2;

    localparam logic [1:0] SRCB_B      = 2'd0;
    localparam logic [1:0] SRCB_FOUR   = 2'd1;
    localparam logic [1:0] SRCB_IMM    = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH = 2'd3;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
    } ctrl_t;

endpackage

// File: rtl/mips_ctrl_decode.sv
// Moore output decode: maps the current state (plus the memory handshake for
// the fetch commit) onto the datapath control word.
module mips_ctrl_decode
    import mips_ctrl_pkg::*;
(
    input  state_e state,
    input  logic   mem_ready,
    output ctrl_t  ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALU_ADD;
                ctrl.pc_src    = PCSRC_ALU;
                // IR and PC only commit once the instruction word is actually back
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            S_DECODE: begin
                ctrl.alu_src_b = SRCB_IMM_SH;
                ctrl.alu_op    = ALU_ADD;
            end
            S_MEM_ADDR, S_ADDI_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_ADD;
            end
            S_MEM_RD: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            S_MEM_WR: begin
                ctrl.i_or_d    = 1'b1;
                ctrl.mem_write = 1'b1;
            end
            S_R_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_B;
                ctrl.alu_op    = ALU_FUNCT;
            end
            S_R_WB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_B;
                ctrl.alu_op        = ALU_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_src        = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                ctrl.pc_write = 1'b1;
                ctrl.pc_src   = PCSRC_JUMP;
            end
            S_ADDI_WB: begin
                ctrl.reg_write = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS sequencer: state register, next-state logic and the sticky
// illegal-opcode flag; output decode lives in mips_ctrl_decode.
//
// state     | meaning
// FETCH     | read instruction at PC, PC += 4 when memory ready
// DECODE    | opcode dispatch, precompute branch target
// MEM_ADDR  | effective address for lw/sw
// MEM_RD    | data read, waits for memory
// MEM_WB    | MDR -> rt
// MEM_WR    | data write, waits for memory
// R_EXEC    | funct-decoded ALU op on A, B
// R_WB      | ALUOut -> rd
// BRANCH    | compare A, B; load PC if equal
// JUMP      | PC <- jump target
// ADDI_EXEC | A + imm
// ADDI_WB   | ALUOut -> rt
// HALT      | illegal opcode, parked until reset
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter bit MEM_WAIT_EN = 1'b1,
    parameter bit ADDI_EN     = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_src,
    output logic       illegal,
    output logic [3:0] state
);

    state_e state_q, state_d;
    logic   illegal_q, illegal_d;
    logic   mem_rdy;
    ctrl_t  ctrl_raw, ctrl;

    assign mem_rdy = MEM_WAIT_EN ? mem_ready : 1'b1;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:     state_d = mem_rdy ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:     state_d = S_R_EXEC;
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = ADDI_EN ? S_ADDI_EXEC : S_HALT;
                    default:      state_d = S_HALT;
                endcase
            end
            S_MEM_ADDR:  state_d = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:    state_d = mem_rdy ? S_MEM_WB : S_MEM_RD;
            S_MEM_WB:    state_d = S_FETCH;
            S_MEM_WR:    state_d = mem_rdy ? S_FETCH : S_MEM_WR;
            S_R_EXEC:    state_d = S_R_WB;
            S_R_WB:      state_d = S_FETCH;
            S_BRANCH:    state_d = S_FETCH;
            S_JUMP:      state_d = S_FETCH;
            S_ADDI_EXEC: state_d = S_ADDI_WB;
            S_ADDI_WB:   state_d = S_FETCH;
            S_HALT:      state_d = S_HALT;
            default:     state_d = S_HALT;
        endcase
    end

    assign illegal_d = illegal_q | (state_d == S_HALT);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    mips_ctrl_decode u_decode (
        .state     (state_q),
        .mem_ready (mem_rdy),
        .ctrl      (ctrl_raw)
    );

    // Reset gates every enable combinationally so an aborted access never pulses
    assign ctrl = rst_n ? ctrl_raw : '0;

    assign pc_write      = ctrl.pc_write;
    assign pc_write_cond = ctrl.pc_write_cond;
    assign i_or_d        = ctrl.i_or_d;
    assign mem_read      = ctrl.mem_read;
    assign mem_write     = ctrl.mem_write;
    assign ir_write      = ctrl.ir_write;
    assign mem_to_reg    = ctrl.mem_to_reg;
    assign reg_dst       = ctrl.reg_dst;
    assign reg_write     = ctrl.reg_write;
    assign alu_src_a     = ctrl.alu_src_a;
    assign alu_src_b     = ctrl.alu_src_b;
    assign alu_op        = ctrl.alu_op;
    assign pc_src        = ctrl.pc_src;
    assign illegal       = rst_n & illegal_q;
    assign state         = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: a table of per-cycle input/expected
// records followed by hand-written illegal-opcode and reset-abort sequences.
module tb_mips_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal;
    logic [1:0] alu_src_b, alu_op, pc_src;
    logic [3:0] state;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mips_multicycle_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .opcode        (opcode),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .i_or_d        (i_or_d),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .mem_to_reg    (mem_to_reg),
        .reg_dst       (reg_dst),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .pc_src        (pc_src),
        .illegal       (illegal),
        .state         (state)
    );

    // {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
    //  mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_src}
    logic [15:0] outs;
    assign outs = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                   mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_src};

    localparam logic [15:0] E_ZERO   = 16'b0000_0000_0000_0000;
    localparam logic [15:0] E_FET_R  = 16'b1001_0100_0001_0000;
    localparam logic [15:0] E_FET_W  = 16'b0001_0000_0001_0000;
    localparam logic [15:0] E_DEC    = 16'b0000_0000_0011_0000;
    localparam logic [15:0] E_MADDR  = 16'b0000_0000_0110_0000;
    localparam logic [15:0] E_MRD    = 16'b0011_0000_0000_0000;
    localparam logic [15:0] E_MWB    = 16'b0000_0010_1000_0000;
    localparam logic [15:0] E_MWR    = 16'b0010_1000_0000_0000;
    localparam logic [15:0] E_REX    = 16'b0000_0000_0100_1000;
    localparam logic [15:0] E_RWB    = 16'b0000_0001_1000_0000;
    localparam logic [15:0] E_BR     = 16'b0100_0000_0100_0101;
    localparam logic [15:0] E_JMP    = 16'b1000_0000_0000_0010;
    localparam logic [15:0] E_AEX    = 16'b0000_0000_0110_0000;
    localparam logic [15:0] E_AWB    = 16'b0000_0000_1000_0000;

    typedef struct {
        logic        r;
        logic [5:0]  op;
        logic        rdy;
        logic [3:0]  es;
        logic [15:0] eo;
        logic        ei;
    } vec_t;

    vec_t tv[$];

    task automatic add(input logic r, input logic [5:0] op, input logic rdy,
                       input logic [3:0] es, input logic [15:0] eo, input logic ei);
        vec_t v;
        v.r = r; v.op = op; v.rdy = rdy; v.es = es; v.eo = eo; v.ei = ei;
        tv.push_back(v);
    endtask

    // Drive one cycle's inputs after the falling edge, check the Moore outputs, let the posedge advance.
    task automatic step(input logic r, input logic [5:0] op, input logic rdy,
                        input logic [3:0] es, input logic [15:0] eo, input logic ei,
                        input string nm);
        @(negedge clk);
        rst_n = r; opcode = op; mem_ready = rdy;
        #1;
        n_tests++;
        if ({state, outs, illegal} !== {es, eo, ei}) begin
            n_fail++;
            $display("FAIL %s: got state=%0d outs=%b illegal=%b, want state=%0d outs=%b illegal=%b",
                     nm, state, outs, illegal, es, eo, ei);
        end
    endtask

    initial begin
        rst_n = 1'b0; opcode = 6'h00; mem_ready = 1'b1;

        // reset for two cycles, then lw with no waits
        add(0, 6'h23, 1, 0, E_ZERO, 0);
        add(0, 6'h23, 1, 0, E_ZERO, 0);
        add(1, 6'h23, 1, 0, E_FET_R, 0);
        add(1, 6'h23, 1, 1, E_DEC, 0);
        add(1, 6'h23, 1, 2, E_MADDR, 0);
        add(1, 6'h23, 1, 3, E_MRD, 0);
        add(1, 6'h23, 1, 4, E_MWB, 0);
        // R-type then beq back to back
        add(1, 6'h00, 1, 0, E_FET_R, 0);
        add(1, 6'h00, 1, 1, E_DEC, 0);
        add(1, 6'h00, 1, 6, E_REX, 0);
        add(1, 6'h00, 1, 7, E_RWB, 0);
        add(1, 6'h04, 1, 0, E_FET_R, 0);
        add(1, 6'h04, 1, 1, E_DEC, 0);
        add(1, 6'h04, 1, 8, E_BR, 0);
        // j
        add(1, 6'h02, 1, 0, E_FET_R, 0);
        add(1, 6'h02, 1, 1, E_DEC, 0);
        add(1, 6'h02, 1, 9, E_JMP, 0);
        // addi
        add(1, 6'h08, 1, 0, E_FET_R, 0);
        add(1, 6'h08, 1, 1, E_DEC, 0);
        add(1, 6'h08, 1, 10, E_AEX, 0);
        add(1, 6'h08, 1, 11, E_AWB, 0);
        // fetch wait, then sw with three wait cycles in MEM_WR
        add(1, 6'h2B, 0, 0, E_FET_W, 0);
        add(1, 6'h2B, 1, 0, E_FET_R, 0);
        add(1, 6'h2B, 1, 1, E_DEC, 0);
        add(1, 6'h2B, 1, 2, E_MADDR, 0);
        add(1, 6'h2B, 0, 5, E_MWR, 0);
        add(1, 6'h2B, 0, 5, E_MWR, 0);
        add(1, 6'h2B, 0, 5, E_MWR, 0);
        add(1, 6'h2B, 1, 5, E_MWR, 0);
        // lw with one read wait
        add(1, 6'h23, 1, 0, E_FET_R, 0);
        add(1, 6'h23, 1, 1, E_DEC, 0);
        add(1, 6'h23, 1, 2, E_MADDR, 0);
        add(1, 6'h23, 0, 3, E_MRD, 0);
        add(1, 6'h23, 1, 3, E_MRD, 0);
        add(1, 6'h23, 1, 4, E_MWB, 0);

        @(posedge clk);
        foreach (tv[i])
            step(tv[i].r, tv[i].op, tv[i].rdy, tv[i].es, tv[i].eo, tv[i].ei,
                 $sformatf("vec%0d", i));

        // illegal opcode: HALT is sticky and silent regardless of mem_ready
        step(1, 6'h3F, 1, 0, E_FET_R, 0, "ill_fetch");
        step(1, 6'h3F, 1, 1, E_DEC, 0, "ill_decode");
        for (int k = 0; k < 10; k++)
            step(1, 6'h3F, logic'(k[0]), 15, E_ZERO, 1, $sformatf("halt%0d", k));
        step(0, 6'h3F, 1, 15, E_ZERO, 0, "halt_rst");
        step(1, 6'h23, 1, 0, E_FET_R, 0, "halt_exit");

        // reset during a stalled MEM_RD aborts with no write-back
        step(1, 6'h23, 1, 1, E_DEC, 0, "abort_dec");
        step(1, 6'h23, 1, 2, E_MADDR, 0, "abort_addr");
        step(1, 6'h23, 0, 3, E_MRD, 0, "abort_wait0");
        step(1, 6'h23, 0, 3, E_MRD, 0, "abort_wait1");
        step(0, 6'h23, 0, 3, E_ZERO, 0, "abort_rst");
        step(1, 6'h23, 1, 0, E_FET_R, 0, "abort_refetch");
        step(1, 6'h00, 1, 1, E_DEC, 0, "abort_dec2");
        step(1, 6'h00, 1, 6, E_REX, 0, "abort_rexec");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
